// File: rtl/sram_arbiter.sv
// sram_arbiter
//   Round-robin arbiter and access sequencer for a 512K x 16 asynchronous
//   SRAM. Two requesters issue single-word reads or writes; each granted
//   access runs IDLE -> SETUP -> ACCESS (ACCESS_CYCLES) -> HOLD -> IDLE and
//   finishes with a one-cycle ack to the granted requester. Every output is
//   a register.
//
// Ports
//   clk, rst                 100 MHz clock, asynchronous active-high reset
//   m0_* / m1_*              requester ports: req (level), we, addr[18:0],
//                            wdata[15:0], be[1:0] in; ack (1-cycle pulse) out
//   rdata[15:0]              read data, valid while the matching ack is high
//   sram_adr[18:0]           SRAM address
//   sram_dat_o / sram_dat_oe SRAM write data and its tristate enable
//   sram_dat_i               SRAM data bus input
//   sram_cs_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n
//                            active-low SRAM controls
module sram_arbiter #(
    parameter int unsigned ACCESS_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [18:0] m0_addr,
    input  logic [15:0] m0_wdata,
    input  logic [1:0]  m0_be,
    output logic        m0_ack,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [18:0] m1_addr,
    input  logic [15:0] m1_wdata,
    input  logic [1:0]  m1_be,
    output logic        m1_ack,
    output logic [15:0] rdata,
    output logic [18:0] sram_adr,
    output logic [15:0] sram_dat_o,
    output logic        sram_dat_oe,
    input  logic [15:0] sram_dat_i,
    output logic        sram_cs_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic        sram_lb_n,
    output logic        sram_ub_n
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        HOLD
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        we_q;
    logic        gnt_q;
    logic        last_q;    // requester granted most recently

    logic        any_req_d;
    logic        gnt_d;
    logic        sel_we_d;
    logic [18:0] sel_addr_d;
    logic [15:0] sel_wdata_d;
    logic [1:0]  sel_be_d;

    // Round-robin: a lone requester wins; under contention the one not
    // granted last wins.
    always_comb begin
        any_req_d = m0_req | m1_req;
        if (m0_req && m1_req) begin
            gnt_d = ~last_q;
        end else begin
            gnt_d = m1_req;
        end
        sel_we_d    = gnt_d ? m1_we    : m0_we;
        sel_addr_d  = gnt_d ? m1_addr  : m0_addr;
        sel_wdata_d = gnt_d ? m1_wdata : m0_wdata;
        sel_be_d    = gnt_d ? m1_be    : m0_be;
    end

    // Outputs are loaded on the edge entering each state, so the pin values
    // seen during a state are the ones that state calls for.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            gnt_q       <= 1'b0;
            last_q      <= 1'b1;
            m0_ack      <= 1'b0;
            m1_ack      <= 1'b0;
            rdata       <= '0;
            sram_adr    <= '0;
            sram_dat_o  <= '0;
            sram_dat_oe <= 1'b0;
            sram_cs_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
            sram_we_n   <= 1'b1;
            sram_lb_n   <= 1'b1;
            sram_ub_n   <= 1'b1;
        end else begin
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (any_req_d) begin
                        gnt_q      <= gnt_d;
                        last_q     <= gnt_d;
                        we_q       <= sel_we_d;
                        sram_adr   <= sel_addr_d;
                        sram_dat_o <= sel_wdata_d;
                        sram_cs_n  <= 1'b0;
                        if (sel_we_d) begin
                            sram_dat_oe <= 1'b1;
                            sram_oe_n   <= 1'b1;
                            sram_lb_n   <= ~sel_be_d[0];
                            sram_ub_n   <= ~sel_be_d[1];
                        end else begin
                            sram_dat_oe <= 1'b0;
                            sram_oe_n   <= 1'b0;
                            sram_lb_n   <= 1'b0;
                            sram_ub_n   <= 1'b0;
                        end
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    cnt_q <= CNT_LOAD;
                    if (we_q) begin
                        sram_we_n <= 1'b0;
                    end
                    state_q <= ACCESS;
                end
                ACCESS: begin
                    if (cnt_q == 4'd0) begin
                        sram_we_n <= 1'b1;
                        sram_oe_n <= 1'b1;
                        if (!we_q) begin
                            rdata <= sram_dat_i;
                        end
                        if (gnt_q) begin
                            m1_ack <= 1'b1;
                        end else begin
                            m0_ack <= 1'b1;
                        end
                        state_q <= HOLD;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                HOLD: begin
                    sram_cs_n   <= 1'b1;
                    sram_lb_n   <= 1'b1;
                    sram_ub_n   <= 1'b1;
                    sram_dat_oe <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter
//   Two arbiter instances (ACCESS_CYCLES = 2 and 1), each attached to its own
//   behavioural asynchronous SRAM. Requests are queued per requester; the
//   bench predicts grant order, ack timing and read data from the
//   round-robin rule, the fixed access length and a shadow word memory.
module tb_sram_arbiter;

    typedef struct {
        logic        we;
        logic [18:0] addr;
        logic [15:0] wdata;
        logic [1:0]  be;
    } op_t;

    logic        clk;
    logic        rst_s   [2];
    logic        req_s   [2][2];
    logic        we_s    [2][2];
    logic [18:0] addr_s  [2][2];
    logic [15:0] wd_s    [2][2];
    logic [1:0]  be_s    [2][2];
    logic        ack_s   [2][2];
    logic [15:0] rdata_s [2];
    logic [18:0] adr_s   [2];
    logic [15:0] dato_s  [2];
    logic [15:0] dati_s  [2];
    logic        doe_s   [2];
    logic        csn_s   [2];
    logic        oen_s   [2];
    logic        wen_s   [2];
    logic        lbn_s   [2];
    logic        ubn_s   [2];

    logic [15:0] mem [2][524288];
    logic [15:0] shadow [int];
    op_t         opq [2][$];
    int          exp_last [2];
    int          vectors;
    int          miscompares;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    for (genvar g = 0; g < 2; g++) begin : g_dut
        sram_arbiter #(.ACCESS_CYCLES((g == 0) ? 2 : 1)) dut (
            .clk        (clk),
            .rst        (rst_s[g]),
            .m0_req     (req_s[g][0]),
            .m0_we      (we_s[g][0]),
            .m0_addr    (addr_s[g][0]),
            .m0_wdata   (wd_s[g][0]),
            .m0_be      (be_s[g][0]),
            .m0_ack     (ack_s[g][0]),
            .m1_req     (req_s[g][1]),
            .m1_we      (we_s[g][1]),
            .m1_addr    (addr_s[g][1]),
            .m1_wdata   (wd_s[g][1]),
            .m1_be      (be_s[g][1]),
            .m1_ack     (ack_s[g][1]),
            .rdata      (rdata_s[g]),
            .sram_adr   (adr_s[g]),
            .sram_dat_o (dato_s[g]),
            .sram_dat_oe(doe_s[g]),
            .sram_dat_i (dati_s[g]),
            .sram_cs_n  (csn_s[g]),
            .sram_oe_n  (oen_s[g]),
            .sram_we_n  (wen_s[g]),
            .sram_lb_n  (lbn_s[g]),
            .sram_ub_n  (ubn_s[g])
        );
        // Asynchronous SRAM read path; a recognisable junk value when not enabled.
        assign dati_s[g] = (!csn_s[g] && !oen_s[g]) ? mem[g][adr_s[g]] : 16'hDEAD;
    end

    // SRAM write: lanes enabled while cs_n and we_n are low are stored.
    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (!csn_s[g] && !wen_s[g]) begin
                if (!lbn_s[g]) mem[g][adr_s[g]][7:0]  <= dato_s[g][7:0];
                if (!ubn_s[g]) mem[g][adr_s[g]][15:8] <= dato_s[g][15:8];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] shadow_rd(input int g, input logic [18:0] a);
        int k;
        k = g * 524288 + int'(a);
        return shadow.exists(k) ? shadow[k] : 16'h0000;
    endfunction

    task automatic shadow_wr(input int g, input op_t op);
        logic [15:0] w;
        w = shadow_rd(g, op.addr);
        if (op.be[0]) w[7:0]  = op.wdata[7:0];
        if (op.be[1]) w[15:8] = op.wdata[15:8];
        shadow[g * 524288 + int'(op.addr)] = w;
    endtask

    task automatic push(input int m, input logic we, input logic [18:0] a,
                        input logic [15:0] d, input logic [1:0] be);
        op_t op;
        op.we = we; op.addr = a; op.wdata = d; op.be = be;
        opq[m].push_back(op);
    endtask

    task automatic drive_reqs(input int g);
        for (int m = 0; m < 2; m++) begin
            if (opq[m].size() > 0) begin
                req_s[g][m]  = 1'b1;
                we_s[g][m]   = opq[m][0].we;
                addr_s[g][m] = opq[m][0].addr;
                wd_s[g][m]   = opq[m][0].wdata;
                be_s[g][m]   = opq[m][0].be;
            end else begin
                req_s[g][m] = 1'b0;
            end
        end
    endtask

    function automatic int pick(input int g);
        if (opq[0].size() > 0 && opq[1].size() > 0) return 1 - exp_last[g];
        if (opq[0].size() > 0) return 0;
        return 1;
    endfunction

    task automatic chk_reset(input int g);
        chk("rst_adr",   32'(adr_s[g]), 32'd0);
        chk("rst_dat_o", 32'(dato_s[g]), 32'd0);
        chk("rst_rdata", 32'(rdata_s[g]), 32'd0);
        chk("rst_ctl",   32'({doe_s[g], csn_s[g], oen_s[g], wen_s[g], lbn_s[g], ubn_s[g]}), 32'b011111);
        chk("rst_ack",   32'({ack_s[g][1], ack_s[g][0]}), 32'd0);
    endtask

    // Runs every queued op on instance g (must be idle, called at a negedge).
    // Accesses are back to back: first ack ac+2 edges after the request,
    // then one ack every ac+3 edges.
    task automatic run(input int g, input int ac);
        int  t, due, who, we_run, cs_hi;
        bit  seen_lo;
        op_t cur;
        drive_reqs(g);
        if (opq[0].size() + opq[1].size() == 0) return;
        who = pick(g); cur = opq[who][0];
        due = ac + 2; t = 0; we_run = 0; cs_hi = 0; seen_lo = 0;
        while (opq[0].size() + opq[1].size() > 0) begin
            @(posedge clk); t++; @(negedge clk);
            chk("bus_conflict", 32'(doe_s[g] && !oen_s[g]), 32'd0);
            if (!wen_s[g]) begin
                we_run++;
                if (we_run == 1) begin
                    chk("wr_lanes", 32'({lbn_s[g], ubn_s[g]}), 32'({~cur.be[0], ~cur.be[1]}));
                    chk("wr_adr",   32'(adr_s[g]), 32'(cur.addr));
                    chk("wr_dat",   32'({doe_s[g], dato_s[g]}), 32'({1'b1, cur.wdata}));
                end
            end else if (we_run > 0) begin
                chk("we_width", 32'(we_run), 32'(ac));
                we_run = 0;
            end
            if (csn_s[g]) begin
                cs_hi++;
            end else begin
                if (seen_lo && cs_hi > 0) chk("cs_gap", 32'(cs_hi), 32'd1);
                seen_lo = 1; cs_hi = 0;
            end
            chk("ack0", 32'(ack_s[g][0]), 32'(t == due && who == 0));
            chk("ack1", 32'(ack_s[g][1]), 32'(t == due && who == 1));
            if (t == due) begin
                if (cur.we) shadow_wr(g, cur);
                else chk("rdata", 32'(rdata_s[g]), 32'(shadow_rd(g, cur.addr)));
                void'(opq[who].pop_front());
                exp_last[g] = who;
                drive_reqs(g);
                if (opq[0].size() + opq[1].size() > 0) begin
                    who = pick(g); cur = opq[who][0];
                    due += ac + 3;
                end
            end
        end
        @(posedge clk); @(negedge clk);
        chk("idle_cs", 32'({csn_s[g], doe_s[g], ack_s[g][1], ack_s[g][0]}), 32'b1000);
    endtask

    task automatic rand_ops(input int n);
        for (int m = 0; m < 2; m++)
            for (int k = 0; k < n; k++)
                push(m, 1'($urandom_range(0, 1)), 19'h100 + 19'($urandom_range(0, 15)),
                     16'($urandom), 2'($urandom_range(0, 3)));
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        exp_last[0] = 1; exp_last[1] = 1;
        for (int g = 0; g < 2; g++) begin
            for (int a = 0; a < 524288; a++) mem[g][a] = 16'h0000;
            rst_s[g] = 1'b1;
            for (int m = 0; m < 2; m++) begin
                req_s[g][m] = 1'b0; we_s[g][m] = 1'b0; addr_s[g][m] = '0;
                wd_s[g][m] = '0; be_s[g][m] = '0;
            end
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset(0); chk_reset(1);
        rst_s[0] = 1'b0; rst_s[1] = 1'b0;
        @(posedge clk); @(negedge clk);

        // Write then read back, single requester.
        push(0, 1'b1, 19'h00010, 16'hBEEF, 2'b11);
        push(0, 1'b0, 19'h00010, 16'h0000, 2'b00);
        run(0, 2);

        // Continuous contention, four accesses each: must alternate m0, m1.
        for (int k = 0; k < 4; k++) begin
            push(0, k[0], 19'h00030 + 19'(k), 16'h1100 + 16'(k), 2'b11);
            push(1, ~k[0], 19'h00040 + 19'(k), 16'h2200 + 16'(k), 2'b11);
        end
        run(0, 2);

        // Byte-lane merge, then a be=00 write that must change nothing.
        push(0, 1'b1, 19'h00020, 16'h1234, 2'b11);
        push(0, 1'b1, 19'h00020, 16'hAB00, 2'b10);
        push(0, 1'b0, 19'h00020, 16'h0000, 2'b00);
        push(0, 1'b1, 19'h00020, 16'hFFFF, 2'b00);
        push(0, 1'b0, 19'h00020, 16'h0000, 2'b00);
        run(0, 2);

        // Only m1, three back-to-back reads.
        push(1, 1'b0, 19'h00010, 16'h0000, 2'b00);
        push(1, 1'b0, 19'h00020, 16'h0000, 2'b00);
        push(1, 1'b0, 19'h00031, 16'h0000, 2'b00);
        run(0, 2);

        // Reset in the middle of a write's ACCESS phase.
        req_s[0][0] = 1'b1; we_s[0][0] = 1'b1; addr_s[0][0] = 19'h7FFF0;
        wd_s[0][0] = 16'h5555; be_s[0][0] = 2'b11;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("abort_in_access", 32'({csn_s[0], wen_s[0]}), 32'b00);
        #1 rst_s[0] = 1'b1;
        #1;
        chk_reset(0);
        req_s[0][0] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("abort_no_ack", 32'({ack_s[0][1], ack_s[0][0]}), 32'd0);
        rst_s[0] = 1'b0;
        exp_last[0] = 1;
        @(posedge clk); @(negedge clk);
        // Pointer is back at reset value: m0 must win this contention.
        push(0, 1'b0, 19'h00010, 16'h0000, 2'b00);
        push(1, 1'b0, 19'h00020, 16'h0000, 2'b00);
        run(0, 2);

        for (int r = 0; r < 3; r++) begin
            rand_ops(5);
            run(0, 2);
        end

        // Short-access instance.
        push(0, 1'b1, 19'h00040, 16'hCAFE, 2'b11);
        push(0, 1'b0, 19'h00040, 16'h0000, 2'b00);
        run(1, 1);
        push(0, 1'b1, 19'h00041, 16'h00C3, 2'b01);
        push(1, 1'b0, 19'h00040, 16'h0000, 2'b00);
        push(0, 1'b0, 19'h00041, 16'h0000, 2'b00);
        push(1, 1'b1, 19'h00040, 16'h7700, 2'b10);
        push(1, 1'b0, 19'h00040, 16'h0000, 2'b00);
        run(1, 1);
        for (int r = 0; r < 2; r++) begin
            rand_ops(5);
            run(1, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
